clk_int_div_dyn: RTL and testbench

//  Runtime-programmable integer clock divider. Successor to the static even-only divider.

---
 rtl/clk_int_div_dyn.sv | 65 ++++++
 tb/tb_clk_int_div_dyn.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clk_int_div_dyn.sv
// clk_int_div_dyn: runtime-programmable integer clock divider, 50% duty for any N, boundary-only divisor updates
module clk_int_div_dyn #(
  parameter int DIV_VALUE_WIDTH = 4,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       test_mode_en_i,
  input  logic [DIV_VALUE_WIDTH-1:0] div_i,
  input  logic                       div_valid_i,
  output logic                       div_ready_o,
  output logic [DIV_VALUE_WIDTH-1:0] cycl_count_o,
  output logic                       clk_o
);
  localparam int W = DIV_VALUE_WIDTH;
  localparam logic [W-1:0] DEF = (DEFAULT_DIV == 0) ? W'(1) : W'(DEFAULT_DIV);
  typedef enum logic [1:0] {IDLE, PEND, PARKED} state_t;
  state_t state, state_nx;
  logic [W-1:0] div_q, pend_q, cnt, div_nx, cnt_nx, n, n_nx;
  logic pend_v, fresh, clk_p, clk_n, byp;
  logic pend_v_nx, clk_p_nx, xfer, bnd, load, stop, parked;
  // fresh marks a cycle whose next edge starts a new period from cnt=0 (after park or bypass)
  always_comb begin
    parked = state == PARKED;
    n = (div_q < W'(2)) ? W'(1) : div_q;
    div_ready_o = state == IDLE || (parked && !pend_v);
    xfer = div_valid_i && div_ready_o;
    bnd = fresh || cnt == n - W'(1);
    stop = bnd && !en_i;
    load = bnd && pend_v && (!parked || en_i);
    div_nx = load ? pend_q : div_q;
    n_nx = (div_nx < W'(2)) ? W'(1) : div_nx;
    cnt_nx = bnd ? '0 : cnt + W'(1);
    clk_p_nx = !stop && n != W'(1) && cnt_nx < (n_nx >> 1);
    pend_v_nx = xfer || (pend_v && !load);
    state_nx = stop ? PARKED : xfer ? PEND : (parked || load) ? IDLE : state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= PARKED;
      div_q <= DEF;
      pend_q <= '0;
      pend_v <= 1'b0;
      cnt <= '0;
      clk_p <= 1'b0;
      fresh <= 1'b1;
    end else begin
      state <= state_nx;
      div_q <= div_nx;
      if (xfer) pend_q <= div_i;
      pend_v <= pend_v_nx;
      cnt <= cnt_nx;
      clk_p <= clk_p_nx;
      fresh <= stop || n == W'(1);
    end
  end
  // falling-edge copies: half-cycle stretch for odd N, and bypass select switched only while clk_i is low
  always_ff @(negedge clk_i) begin
    clk_n <= clk_p;
    byp <= n == W'(1) && (en_i || !parked);
  end
  assign cycl_count_o = cnt;
  assign clk_o = (test_mode_en_i || byp) ? clk_i : (clk_p || (n[0] && clk_n && !parked));
endmodule

// File: tb/tb_clk_int_div_dyn.sv
// tb_clk_int_div_dyn: directed checks of divide ratios, handshake, parking, reset and bypass
`timescale 1ns/1ps
module tb_clk_int_div_dyn;
  logic clk_i = 1'b0, rst_i = 1'b1, en_i = 1'b1, test_mode_en_i = 1'b0, div_valid_i = 1'b0;
  logic [3:0] div_i = 4'd0;
  logic [3:0] cycl_count_o;
  logic div_ready_o, clk_o;
  int errs = 0, checks = 0;
  int hi, per;
  bit mon_en = 1'b0;
  realtime last_t = 0.0, min_w = 1000.0;

  always #5 clk_i = ~clk_i;

  clk_int_div_dyn #(.DIV_VALUE_WIDTH(4), .DEFAULT_DIV(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .test_mode_en_i(test_mode_en_i),
    .div_i(div_i), .div_valid_i(div_valid_i), .div_ready_o(div_ready_o),
    .cycl_count_o(cycl_count_o), .clk_o(clk_o)
  );

  always @(clk_o) begin
    if (mon_en && !test_mode_en_i && ($realtime - last_t) < min_w) min_w = $realtime - last_t;
    last_t = $realtime;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_cnt(input int v);
    step();
    for (int i = 0; i < 64 && int'(cycl_count_o) != v; i++) step();
    chk("wait_cnt", int'(cycl_count_o), v);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 64 && !div_ready_o; i++) step();
    chk("wait_ready", int'(div_ready_o), 1);
  endtask

  task automatic send(input int v);
    wait_ready();
    div_i = 4'(v);
    div_valid_i = 1'b1;
    step();
    div_valid_i = 1'b0;
  endtask

  task automatic meas(output int h, output int p);
    int k, t0, t1;
    k = 0;
    @(posedge clk_i);
    #1;
    while (clk_o !== 1'b0 && k < 200) begin #5; k++; end
    while (clk_o !== 1'b1 && k < 200) begin #5; k++; end
    t0 = k;
    while (clk_o !== 1'b0 && k < 200) begin #5; k++; end
    t1 = k;
    while (clk_o !== 1'b1 && k < 200) begin #5; k++; end
    h = (t1 - t0) * 5;
    p = (k - t0) * 5;
    if (k >= 200) begin h = -1; p = -1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("rst_clk", int'(clk_o), 0);
    chk("rst_ready", int'(div_ready_o), 1);
    chk("rst_cnt", int'(cycl_count_o), 0);
    rst_i = 1'b0;
    mon_en = 1'b1;
    step();
    chk("first_rise", int'(clk_o), 1);
    chk("first_cnt", int'(cycl_count_o), 0);
    step();
    chk("n4_c1_clk", int'(clk_o), 1);
    chk("n4_c1_cnt", int'(cycl_count_o), 1);
    step();
    chk("n4_c2_clk", int'(clk_o), 0);
    meas(hi, per);
    chk("n4_high", hi, 20);
    chk("n4_period", per, 40);
    // switch 4 -> 3 mid-period
    wait_cnt(1);
    send(3);
    chk("t2_ready_drop", int'(div_ready_o), 0);
    chk("t2_cnt2", int'(cycl_count_o), 2);
    step();
    chk("t2_cnt3", int'(cycl_count_o), 3);
    chk("t2_ready_hold", int'(div_ready_o), 0);
    step();
    chk("t2_bnd_cnt", int'(cycl_count_o), 0);
    chk("t2_bnd_clk", int'(clk_o), 1);
    chk("t2_ready_back", int'(div_ready_o), 1);
    meas(hi, per);
    chk("n3_high", hi, 15);
    chk("n3_period", per, 30);
    // bypass via 0 then 1
    send(0);
    repeat (6) step();
    chk("byp0_cnt", int'(cycl_count_o), 0);
    meas(hi, per);
    chk("byp0_high", hi, 5);
    chk("byp0_period", per, 10);
    send(1);
    chk("byp1_ready_drop", int'(div_ready_o), 0);
    step();
    chk("byp1_ready_back", int'(div_ready_o), 1);
    meas(hi, per);
    chk("byp1_high", hi, 5);
    chk("byp1_period", per, 10);
    // held request while not ready
    wait_ready();
    div_i = 4'd4;
    div_valid_i = 1'b1;
    step();
    chk("t4_ready_drop", int'(div_ready_o), 0);
    div_i = 4'd5;
    step();
    chk("t4_ready_back", int'(div_ready_o), 1);
    step();
    chk("t4_taken", int'(div_ready_o), 0);
    div_valid_i = 1'b0;
    wait_cnt(4);
    meas(hi, per);
    chk("n5_high", hi, 25);
    chk("n5_period", per, 50);
    // parking at N=4
    send(4);
    wait_ready();
    wait_cnt(1);
    en_i = 1'b0;
    step();
    chk("park_cnt2", int'(cycl_count_o), 2);
    step();
    chk("park_cnt3", int'(cycl_count_o), 3);
    step();
    chk("park_cnt0", int'(cycl_count_o), 0);
    chk("park_clk", int'(clk_o), 0);
    step();
    chk("park_hold_clk", int'(clk_o), 0);
    chk("park_hold_cnt", int'(cycl_count_o), 0);
    chk("park_ready", int'(div_ready_o), 1);
    @(negedge clk_i);
    #1;
    test_mode_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("tm_high", int'(clk_o), 1);
    @(negedge clk_i);
    #1;
    chk("tm_low", int'(clk_o), 0);
    test_mode_en_i = 1'b0;
    step();
    chk("park_after_tm", int'(clk_o), 0);
    en_i = 1'b1;
    step();
    chk("unpark_rise", int'(clk_o), 1);
    chk("unpark_cnt", int'(cycl_count_o), 0);
    step();
    chk("unpark_cnt1", int'(cycl_count_o), 1);
    // reset during high phase at N=6
    send(6);
    wait_ready();
    wait_cnt(1);
    chk("n6_high_before_rst", int'(clk_o), 1);
    rst_i = 1'b1;
    step();
    chk("mrst_clk", int'(clk_o), 0);
    chk("mrst_ready", int'(div_ready_o), 1);
    chk("mrst_cnt", int'(cycl_count_o), 0);
    rst_i = 1'b0;
    step();
    chk("mrst_rise", int'(clk_o), 1);
    meas(hi, per);
    chk("mrst_high", hi, 20);
    chk("mrst_period", per, 40);
    chk("min_pulse_ok", int'(min_w >= 5.0), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
